// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage register with valid/ready handshake, stall and flush
// Optional feature: define PIPE_STAGE_BUF_SKID_EN for the 2-entry skid buffer with registered in_ready.
module pipe_stage_buf #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic [1:0]               count
);
    localparam int DW = NUM_CH * DATA_W;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;

    logic              main_valid, main_valid_n;
    logic [DW-1:0]     main_data, main_data_n;
    logic [TAG_W-1:0]  main_tag, main_tag_n;
    logic [1:0]        count_q, count_n;
    logic              in_xfer, out_xfer;

    assign out_xfer = main_valid && out_ready;
    // A beat offered during flush is dropped even when in_ready is high.
    assign in_xfer  = in_valid && in_ready && !flush;

`ifdef PIPE_STAGE_BUF_SKID_EN
    localparam logic [1:0] ST_TWO = 2'd2;

    logic              skid_valid, skid_valid_n;
    logic [DW-1:0]     skid_data, skid_data_n;
    logic [TAG_W-1:0]  skid_tag, skid_tag_n;
    logic              in_ready_q;

    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_tag_n   = main_tag;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_tag_n   = skid_tag;
        if (flush) begin
            main_valid_n = 1'b0;
            main_tag_n   = '0;
            skid_valid_n = 1'b0;
            skid_tag_n   = '0;
        end else if (!main_valid || out_xfer) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                main_tag_n   = skid_tag;
                skid_valid_n = 1'b0;
                skid_tag_n   = '0;
            end else if (in_xfer) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
                main_tag_n   = in_tag;
            end else begin
                main_valid_n = 1'b0;
                main_tag_n   = '0;
            end
        end else if (in_xfer) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_tag_n   = in_tag;
        end
        count_n = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end

    // in_ready looks one state ahead so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_tag   <= skid_tag_n;
            in_ready_q <= (count_n != ST_TWO);
        end
    end

    assign in_ready = in_ready_q;
`else
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_tag_n   = main_tag;
        if (flush) begin
            main_valid_n = 1'b0;
            main_tag_n   = '0;
        end else if (in_xfer) begin
            main_valid_n = 1'b1;
            main_data_n  = in_data;
            main_tag_n   = in_tag;
        end else if (out_xfer) begin
            main_valid_n = 1'b0;
            main_tag_n   = '0;
        end
        count_n = main_valid_n ? ST_ONE : ST_EMPTY;
    end

    assign in_ready = !main_valid || out_ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_tag   <= '0;
            count_q    <= ST_EMPTY;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            main_tag   <= main_tag_n;
            count_q    <= count_n;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_tag   = main_valid ? main_tag : '0;
    assign count     = count_q;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf (both skid and single-register builds)
module tb_pipe_stage_buf;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int DW     = NUM_CH * DATA_W;
`ifdef PIPE_STAGE_BUF_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]     in_data, out_data;
    logic [TAG_W-1:0]  in_tag, out_tag;
    logic [1:0]        count;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_buf #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
    } beat_t;

    // Reference model: an ordered FIFO of held beats plus the data last seen at the head.
    beat_t         q[$];
    logic [DW-1:0] last_data;

    function automatic logic [DW-1:0] rep(input logic [DATA_W-1:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic model_check();
        logic              ev;
        logic [TAG_W-1:0]  et;
        logic [DW-1:0]     ed;
        ev = q.size() != 0;
        et = ev ? q[0].tag : '0;
        ed = ev ? q[0].data : last_data;
        chk("m_out_valid", 128'(out_valid), 128'(ev));
        chk("m_out_tag",   128'(out_tag),   128'(et));
        chk("m_out_data",  128'(out_data),  128'(ed));
        chk("m_count",     128'(count),     128'(q.size()));
        chk("m_in_ready",  128'(in_ready),  128'(model_ready()));
    endtask

    task automatic model_reset();
        q.delete();
        last_data = '0;
    endtask

    task automatic drive(input logic f, input logic iv, input logic [DW-1:0] d,
                         input logic [TAG_W-1:0] t, input logic ordy);
        @(negedge clk);
        flush = f; in_valid = iv; in_data = d; in_tag = t; out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        logic  acc, pop;
        beat_t b;
        acc = in_valid && model_ready();
        pop = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                b.data = in_data;
                b.tag  = in_tag;
                q.push_back(b);
            end
        end
        if (q.size() != 0) last_data = q[0].data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 0; in_valid = 0; in_data = '0; in_tag = '0; out_ready = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic             iv;
        logic [7:0]       dv;
        logic [TAG_W-1:0] tg;
        logic [1:0]       e_count;
        logic             e_valid;
        logic [TAG_W-1:0] e_tag;
        logic [7:0]       e_dv;
        logic             e_rdy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        reset = 1'b1; flush = 0; in_valid = 0; in_data = '0; in_tag = '0; out_ready = 0;
        model_reset();
        #1;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_count",     128'(count),     128'(0));
        chk("reset_out_data",  128'(out_data),  128'(0));
        do_reset();

        // Streaming 1,2,3 then tag-9 drain; expectations are observed before the edge that applies the row.
        vecs[0] = '{1'b1, 8'h1, 5'd1, 2'd0, 1'b0, 5'd0, 8'h0, 1'b1};
        vecs[1] = '{1'b1, 8'h2, 5'd2, 2'd1, 1'b1, 5'd1, 8'h1, 1'b1};
        vecs[2] = '{1'b1, 8'h3, 5'd3, 2'd1, 1'b1, 5'd2, 8'h2, 1'b1};
        vecs[3] = '{1'b0, 8'h0, 5'd0, 2'd1, 1'b1, 5'd3, 8'h3, 1'b1};
        vecs[4] = '{1'b0, 8'h0, 5'd0, 2'd0, 1'b0, 5'd0, 8'h3, 1'b1};
        vecs[5] = '{1'b1, 8'h9, 5'd9, 2'd0, 1'b0, 5'd0, 8'h3, 1'b1};
        vecs[6] = '{1'b0, 8'h0, 5'd0, 2'd1, 1'b1, 5'd9, 8'h9, 1'b1};
        vecs[7] = '{1'b0, 8'h0, 5'd0, 2'd0, 1'b0, 5'd0, 8'h9, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vecs[i].iv, rep(32'(vecs[i].dv)), vecs[i].tg, 1'b1);
            chk("tbl_out_valid", 128'(out_valid), 128'(vecs[i].e_valid));
            chk("tbl_out_tag",   128'(out_tag),   128'(vecs[i].e_tag));
            chk("tbl_out_data",  128'(out_data),  128'(rep(32'(vecs[i].e_dv))));
            chk("tbl_count",     128'(count),     128'(vecs[i].e_count));
            chk("tbl_in_ready",  128'(in_ready),  128'(vecs[i].e_rdy));
            model_check();
            tick();
        end

`ifdef PIPE_STAGE_BUF_SKID_EN
        // Stall with tags 4,5,6: skid fills, in_ready drops, order preserved on release.
        do_reset();
        drive(0, 1, rep(32'h4), 5'd4, 0); model_check(); tick();
        drive(0, 1, rep(32'h5), 5'd5, 0);
        chk("stall_count1", 128'(count), 128'(1));
        chk("stall_rdy1", 128'(in_ready), 128'(1));
        model_check(); tick();
        drive(0, 1, rep(32'h6), 5'd6, 0);
        chk("stall_count2", 128'(count), 128'(2));
        chk("stall_rdy0", 128'(in_ready), 128'(0));
        model_check(); tick();
        drive(0, 1, rep(32'h6), 5'd6, 1);
        chk("stall_hold_tag4", 128'(out_tag), 128'(4));
        model_check(); tick();
        drive(0, 1, rep(32'h6), 5'd6, 1);
        chk("stall_tag5", 128'(out_tag), 128'(5));
        model_check(); tick();
        drive(0, 0, '0, '0, 1);
        chk("stall_tag6", 128'(out_tag), 128'(6));
        chk("stall_data6", 128'(out_data), 128'(rep(32'h6)));
        model_check(); tick();

        // Flush with two entries held.
        do_reset();
        drive(0, 1, rep(32'h1), 5'd1, 0); tick();
        drive(0, 1, rep(32'h2), 5'd2, 0); tick();
        drive(1, 1, rep(32'h7), 5'd7, 0);
        chk("flush_pre_count", 128'(count), 128'(2));
        tick();
`else
        // Single register: in_ready follows out_ready combinationally while full.
        do_reset();
        drive(0, 1, rep(32'h1), 5'd1, 1); tick();
        drive(0, 1, rep(32'h2), 5'd2, 0);
        chk("ns_rdy_stalled", 128'(in_ready), 128'(0));
        model_check();
        out_ready = 1'b1;
        #1;
        chk("ns_rdy_release", 128'(in_ready), 128'(1));
        model_check(); tick();
        drive(0, 0, '0, '0, 0);
        chk("ns_no_bubble_tag", 128'(out_tag), 128'(2));
        model_check(); tick();

        // Flush with one entry held.
        do_reset();
        drive(0, 1, rep(32'h1), 5'd1, 0); tick();
        drive(1, 1, rep(32'h7), 5'd7, 0);
        chk("flush_pre_count", 128'(count), 128'(1));
        tick();
`endif
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, '0, 1);
            chk("flush_out_valid", 128'(out_valid), 128'(0));
            chk("flush_out_tag",   128'(out_tag),   128'(0));
            chk("flush_count",     128'(count),     128'(0));
            model_check(); tick();
        end

        // Asynchronous reset with one entry held, checked before any clock edge.
        drive(0, 1, rep(32'hA), 5'd10, 0); tick();
        drive(0, 0, '0, '0, 0);
        chk("pre_reset_count", 128'(count), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("areset_out_valid", 128'(out_valid), 128'(0));
        chk("areset_out_data",  128'(out_data),  128'(0));
        chk("areset_out_tag",   128'(out_tag),   128'(0));
        chk("areset_count",     128'(count),     128'(0));
        do_reset();

        // Randomized traffic against the FIFO model.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  {$urandom, $urandom, $urandom}, TAG_W'($urandom), $urandom_range(0, 2) != 0);
            model_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
